// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial WIDTH-bit subtractor: one shared 4-bit ripple-borrow slice,
// least-significant nibble first, borrow carried between cycles in a register.

// 4-bit ripple-borrow subtractor slice: diff = a - b - bin, bout = borrow out.
module ripple_carry_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);
  logic [4:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[4];
endmodule

// state | meaning
// IDLE  | ready for a request; operands latched on start
// RUN   | one nibble per cycle through the slice, LSB nibble first
// DONE  | one-cycle done pulse; results already registered
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, acc, acc_next;
  logic              br_reg;
  logic [IDXW-1:0]   idx;
  logic [3:0]        a_nib, b_nib, slice_diff;
  logic              slice_bout;
  logic              last;

  assign last = (idx == IDXW'(NIB - 1));

  // Select the operand nibbles addressed by idx.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_reg[i*4 +: 4];
        b_nib = b_reg[i*4 +: 4];
      end
    end
  end

  ripple_carry_subtractor u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (br_reg),
    .diff (slice_diff),
    .bout (slice_bout)
  );

  // Accumulator with the current slice result merged in at idx.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) acc_next[i*4 +: 4] = slice_diff;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, nibble stepping and result registers; results only
  // change on the final nibble so partial sums are never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      br_reg <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            br_reg <= bin;
            idx    <= '0;
            acc    <= '0;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          br_reg <= slice_bout;
          idx    <= last ? '0 : idx + IDXW'(1);
          if (last) begin
            diff <= acc_next;
            bout <= slice_bout;
            zero <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             bin = 1'b0;
  logic             ready, busy, done, bout, zero;
  logic [WIDTH-1:0] diff;

  int n_pass  = 0;
  int n_total = 0;
  logic [WIDTH-1:0] prev_diff = '0;

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One full request: accept, RUN cycles, DONE pulse, back to IDLE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic ez);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    for (int k = 0; k < NIB; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check("run_busy", busy, 1);
      check("run_done_low", done, 0);
      check("run_diff_hold", diff, prev_diff);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_ready", ready, 0);
    check("diff", diff, ed);
    check("bout", bout, eb);
    check("zero", zero, ez);
    @(posedge clk); #1;
    check("back_ready", ready, 1);
    check("done_once", done, 0);
    prev_diff = ed;
  endtask

  logic [16:0] exp_q[$];
  int          acc_cyc[$];
  int          done_cnt;
  logic [16:0] full, got;

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    vecs[6] = '{16'h0001, 16'h8000, 1'b0, 16'h8001, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1, 1'b0};

    // Asynchronous reset between edges.
    #1 rst = 1'b1;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].zero);
      if (i == 3) begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_diff", diff, 16'h0000);
        check("hold_zero", zero, 1);
        check("hold_ready", ready, 1);
      end
    end

    // start held high, operands changing every cycle.
    done_cnt = 0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(negedge clk);
      a     = 16'h0F00 + 16'(cyc) * 16'h0135;
      b     = 16'(cyc) * 16'h0217;
      bin   = cyc[0];
      start = (cyc < 20);
      if (ready && start) begin
        full = {1'b0, a} - {1'b0, b} - 17'(bin);
        exp_q.push_back(full);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("held_unexpected_done", 1, 0);
        end else begin
          full = exp_q.pop_front();
          got  = {bout, diff};
          check("held_result", got, full);
          check("held_zero", zero, (full[15:0] == 16'h0000));
          prev_diff = full[15:0];
        end
      end
    end
    start = 1'b0;
    check("held_accepts", acc_cyc.size(), 4);
    check("held_done_count", done_cnt, 4);
    check("held_pending", exp_q.size(), 0);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("held_spacing", acc_cyc[i] - acc_cyc[i-1], 6);

    // start and rst together: reset wins.
    @(negedge clk); start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_start_ready", ready, 1);
    check("rst_start_busy", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    prev_diff = '0;

    // Leave nonzero results, then abort an operation in its 2nd RUN cycle.
    run_op(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0);
    @(negedge clk); a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_zero", zero, 0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    prev_diff = '0;
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
